// File: rtl/axi_stream_pkt_gen.sv
// AXI4-Stream packet generator: bursts of fixed-length packets carrying an incrementing word from a seed.
// Optional inter-packet idle gap compiled in with `define AXIS_PKT_GEN_GAP_EN.
module axi_stream_pkt_gen #(
    parameter int DATA_W = 32,
    parameter int LEN_W  = 8,
    parameter int CNT_W  = 8,
    parameter int GAP_W  = 4
) (
    input  logic              aclk,
    input  logic              areset_n,
    input  logic              start,
    input  logic [LEN_W-1:0]  cfg_pkt_len,
    input  logic [CNT_W-1:0]  cfg_pkt_cnt,
    input  logic [DATA_W-1:0] cfg_seed,
    input  logic [GAP_W-1:0]  cfg_gap,
    output logic              m_axis_tvalid,
    input  logic              m_axis_tready,
    output logic [DATA_W-1:0] m_axis_tdata,
    output logic              m_axis_tlast,
    output logic              busy,
    output logic              done
);

`ifdef AXIS_PKT_GEN_GAP_EN
    typedef enum logic [1:0] {S_IDLE, S_SEND, S_GAP} state_t;
`else
    typedef enum logic [1:0] {S_IDLE, S_SEND} state_t;
`endif

    state_t            state_q, state_d;
    logic [DATA_W-1:0] word_q, word_d;
    logic [DATA_W-1:0] tdata_q, tdata_d;
    logic [LEN_W-1:0]  beat_q, beat_d;
    logic [LEN_W-1:0]  len_q, len_d;
    logic [CNT_W-1:0]  pkt_q, pkt_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              tvalid_q, tvalid_d;
    logic              tlast_q, tlast_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
`ifdef AXIS_PKT_GEN_GAP_EN
    logic [GAP_W-1:0]  gap_q, gap_d;
    logic [GAP_W-1:0]  gap_cnt_q, gap_cnt_d;
`else
    logic              unused_cfg_gap;
    assign unused_cfg_gap = ^cfg_gap;
`endif

    logic              hs;
    logic [LEN_W-1:0]  len_eff;
    logic [DATA_W-1:0] word_inc;

    assign hs       = tvalid_q & m_axis_tready;
    assign len_eff  = (cfg_pkt_len == '0) ? LEN_W'(1) : cfg_pkt_len;
    assign word_inc = word_q + DATA_W'(1);

    always_comb begin
        // NOTE: every variable gets its hold value first, so no path through the case infers a latch.
        state_d  = state_q;
        word_d   = word_q;
        tdata_d  = tdata_q;
        beat_d   = beat_q;
        len_d    = len_q;
        pkt_d    = pkt_q;
        cnt_d    = cnt_q;
        tvalid_d = tvalid_q;
        tlast_d  = tlast_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
`ifdef AXIS_PKT_GEN_GAP_EN
        gap_d     = gap_q;
        gap_cnt_d = gap_cnt_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    len_d  = len_eff;
                    cnt_d  = cfg_pkt_cnt;
                    word_d = cfg_seed;
                    beat_d = '0;
                    pkt_d  = '0;
`ifdef AXIS_PKT_GEN_GAP_EN
                    gap_d  = cfg_gap;
`endif
                    if (cfg_pkt_cnt == '0) begin
                        done_d = 1'b1;
                    end else begin
                        state_d  = S_SEND;
                        tvalid_d = 1'b1;
                        busy_d   = 1'b1;
                        tdata_d  = cfg_seed;
                        tlast_d  = (len_eff == LEN_W'(1));
                    end
                end
            end
            S_SEND: begin
                if (hs) begin
                    word_d = word_inc;
                    if (tlast_q) begin
                        beat_d = '0;
                        pkt_d  = pkt_q + CNT_W'(1);
                        if (pkt_q == cnt_q - CNT_W'(1)) begin
                            state_d  = S_IDLE;
                            tvalid_d = 1'b0;
                            tdata_d  = '0;
                            tlast_d  = 1'b0;
                            busy_d   = 1'b0;
                            done_d   = 1'b1;
                        end else begin
                            // Back-to-back by default; a non-zero gap overrides with an idle stretch.
                            tdata_d = word_inc;
                            tlast_d = (len_q == LEN_W'(1));
`ifdef AXIS_PKT_GEN_GAP_EN
                            if (gap_q != '0) begin
                                state_d   = S_GAP;
                                gap_cnt_d = gap_q;
                                tvalid_d  = 1'b0;
                                tdata_d   = '0;
                                tlast_d   = 1'b0;
                            end
`endif
                        end
                    end else begin
                        beat_d  = beat_q + LEN_W'(1);
                        tdata_d = word_inc;
                        tlast_d = (LEN_W'(beat_q + LEN_W'(1)) == len_q - LEN_W'(1));
                    end
                end
            end
`ifdef AXIS_PKT_GEN_GAP_EN
            S_GAP: begin
                if (gap_cnt_q == GAP_W'(1)) begin
                    state_d  = S_SEND;
                    tvalid_d = 1'b1;
                    tdata_d  = word_q;
                    tlast_d  = (len_q == LEN_W'(1));
                end else begin
                    gap_cnt_d = gap_cnt_q - GAP_W'(1);
                end
            end
`endif
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge aclk or negedge areset_n) begin
        if (!areset_n) begin
            state_q  <= S_IDLE;
            word_q   <= '0;
            tdata_q  <= '0;
            beat_q   <= '0;
            len_q    <= '0;
            pkt_q    <= '0;
            cnt_q    <= '0;
            tvalid_q <= 1'b0;
            tlast_q  <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
`ifdef AXIS_PKT_GEN_GAP_EN
            gap_q     <= '0;
            gap_cnt_q <= '0;
`endif
        end else begin
            // NOTE: non-blocking so every register samples the pre-edge value of every other.
            state_q  <= state_d;
            word_q   <= word_d;
            tdata_q  <= tdata_d;
            beat_q   <= beat_d;
            len_q    <= len_d;
            pkt_q    <= pkt_d;
            cnt_q    <= cnt_d;
            tvalid_q <= tvalid_d;
            tlast_q  <= tlast_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
`ifdef AXIS_PKT_GEN_GAP_EN
            gap_q     <= gap_d;
            gap_cnt_q <= gap_cnt_d;
`endif
        end
    end

    assign m_axis_tvalid = tvalid_q;
    assign m_axis_tdata  = tdata_q;
    assign m_axis_tlast  = tlast_q;
    assign busy          = busy_q;
    assign done          = done_q;

endmodule

// File: tb/tb_axi_stream_pkt_gen.sv
// Scoreboard bench for axi_stream_pkt_gen: expected beats queued at start, popped on each handshake.
module tb_axi_stream_pkt_gen;
    localparam int DATA_W = 32;
    localparam int LEN_W  = 8;
    localparam int CNT_W  = 8;
    localparam int GAP_W  = 4;

    typedef struct {
        logic [DATA_W-1:0] data;
        logic              last;
    } beat_t;

    logic              aclk = 1'b0;
    logic              areset_n;
    logic              start;
    logic [LEN_W-1:0]  cfg_pkt_len;
    logic [CNT_W-1:0]  cfg_pkt_cnt;
    logic [DATA_W-1:0] cfg_seed;
    logic [GAP_W-1:0]  cfg_gap;
    logic              m_axis_tvalid;
    logic              m_axis_tready;
    logic [DATA_W-1:0] m_axis_tdata;
    logic              m_axis_tlast;
    logic              busy;
    logic              done;

    int    checks = 0;
    int    errors = 0;
    beat_t exp_q[$];
    int    exp_gap = 0;
    bit    prev_stall = 0;
    logic [DATA_W-1:0] prev_data;
    logic  prev_last;
    bit    after_last = 0;
    int    idle_cnt = 0;

    always #5 aclk = ~aclk;

    axi_stream_pkt_gen #(
        .DATA_W(DATA_W), .LEN_W(LEN_W), .CNT_W(CNT_W), .GAP_W(GAP_W)
    ) dut (
        .aclk(aclk), .areset_n(areset_n), .start(start),
        .cfg_pkt_len(cfg_pkt_len), .cfg_pkt_cnt(cfg_pkt_cnt),
        .cfg_seed(cfg_seed), .cfg_gap(cfg_gap),
        .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
        .m_axis_tdata(m_axis_tdata), .m_axis_tlast(m_axis_tlast),
        .busy(busy), .done(done)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
        end
    endtask

    // Monitor on the falling edge: inputs settle just after the rising edge.
    always @(negedge aclk) begin
        if (!areset_n) begin
            prev_stall = 0;
            after_last = 0;
        end else begin
            if (prev_stall) begin
                check("stall_valid", m_axis_tvalid, 1);
                check("stall_data", m_axis_tdata, prev_data);
                check("stall_last", m_axis_tlast, prev_last);
            end
            if (m_axis_tvalid) begin
                if (after_last) begin
                    check("gap_len", idle_cnt, exp_gap);
                    after_last = 0;
                end
                if (m_axis_tready) begin
                    if (exp_q.size() == 0) begin
                        check("extra_beat", 1, 0);
                    end else begin
                        beat_t e;
                        e = exp_q.pop_front();
                        check("tdata", m_axis_tdata, e.data);
                        check("tlast", m_axis_tlast, e.last);
                    end
                    if (m_axis_tlast) begin
                        after_last = 1;
                        idle_cnt   = 0;
                    end
                    prev_stall = 0;
                end else begin
                    prev_stall = 1;
                    prev_data  = m_axis_tdata;
                    prev_last  = m_axis_tlast;
                end
            end else begin
                prev_stall = 0;
                check("tdata_idle", m_axis_tdata, 0);
                check("tlast_idle", m_axis_tlast, 0);
                if (!busy) after_last = 0;
                else if (after_last) idle_cnt++;
            end
        end
    end

    task automatic run(input logic [DATA_W-1:0] seed, input int len, input int cnt,
                       input int gap, input bit rand_rdy, input bit hold_start);
        int len_eff, gap_eff, exp_cyc, cyc, busy_cyc;
        logic [DATA_W-1:0] w;
        len_eff = (len == 0) ? 1 : len;
`ifdef AXIS_PKT_GEN_GAP_EN
        gap_eff = gap;
`else
        gap_eff = 0;
`endif
        w = seed;
        for (int p = 0; p < cnt; p++) begin
            for (int b = 0; b < len_eff; b++) begin
                exp_q.push_back('{data: w, last: (b == len_eff - 1)});
                w = w + 1;
            end
        end
        exp_gap = gap_eff;
        exp_cyc = cnt * len_eff + ((cnt > 0) ? (cnt - 1) * gap_eff : 0);

        cfg_pkt_len   = len[LEN_W-1:0];
        cfg_pkt_cnt   = cnt[CNT_W-1:0];
        cfg_seed      = seed;
        cfg_gap       = gap[GAP_W-1:0];
        start         = 1'b1;
        m_axis_tready = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
        @(posedge aclk); #1;
        if (hold_start) begin
            cfg_seed    = ~seed;
            cfg_pkt_len = 8'd3;
            cfg_pkt_cnt = 8'd7;
            cfg_gap     = 4'd1;
        end else begin
            start = 1'b0;
        end
        if (cnt != 0) check("start_valid", m_axis_tvalid, 1);

        cyc = 0;
        busy_cyc = 0;
        while (!done && cyc < 2000) begin
            if (busy) busy_cyc++;
            m_axis_tready = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
            @(posedge aclk); #1;
            cyc++;
        end
        start = 1'b0;
        check("done_seen", done, 1);
        if (!rand_rdy) begin
            check("done_lat", cyc, exp_cyc);
            check("busy_cycles", busy_cyc, exp_cyc);
        end
        check("beats_left", exp_q.size(), 0);
        check("busy_at_done", busy, 0);
        check("valid_at_done", m_axis_tvalid, 0);
        exp_q.delete();
        m_axis_tready = 1'b1;
        @(posedge aclk); #1;
        check("done_pulse", done, 0);
        check("no_restart", busy, 0);
        check("no_restart_valid", m_axis_tvalid, 0);
    endtask

    initial begin
        areset_n      = 1'b0;
        start         = 1'b0;
        cfg_pkt_len   = '0;
        cfg_pkt_cnt   = '0;
        cfg_seed      = '0;
        cfg_gap       = '0;
        m_axis_tready = 1'b1;
        repeat (2) @(posedge aclk);
        #1;
        check("rst_tvalid", m_axis_tvalid, 0);
        check("rst_tdata", m_axis_tdata, 0);
        check("rst_tlast", m_axis_tlast, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        areset_n = 1'b1;
        @(posedge aclk); #1;

        run(32'h0000_1000, 4, 1, 0, 0, 0);
        run(32'hFFFF_FFFE, 3, 2, 0, 0, 0);
        run(32'h1234_5678, 5, 1, 0, 1, 0);
        run(32'h0000_0200, 0, 3, 0, 0, 0);
        run(32'h0000_0300, 4, 0, 0, 0, 0);
        run(32'h0000_0400, 2, 3, 3, 0, 0);
        run(32'h0000_0500, 2, 3, 1, 1, 0);
        run(32'h0000_0600, 3, 2, 0, 0, 1);
        run(32'h0000_0700, 255, 1, 0, 0, 0);

        // Reset mid-packet: stream abandoned, no done.
        for (int b = 0; b < 8; b++) exp_q.push_back('{data: 32'h55 + b, last: (b == 7)});
        cfg_seed    = 32'h55;
        cfg_pkt_len = 8'd8;
        cfg_pkt_cnt = 8'd1;
        start       = 1'b1;
        @(posedge aclk); #1;
        start = 1'b0;
        repeat (3) @(posedge aclk);
        #2;
        areset_n = 1'b0;
        #1;
        check("mid_rst_tvalid", m_axis_tvalid, 0);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_done", done, 0);
        check("mid_rst_tdata", m_axis_tdata, 0);
        exp_q.delete();
        repeat (2) @(posedge aclk);
        #1;
        areset_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge aclk); #1;
            check("post_rst_done", done, 0);
        end
        run(32'h0000_00A0, 2, 1, 0, 0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/axi_stream_pkt_gen.md
# axi_stream_pkt_gen

Parametrised AXI4-Stream packet generator: on a start pulse it emits a run-time-configured number of packets, each of run-time-configured length, carrying an incrementing data pattern from a loadable seed. It is a master-side traffic source for stream datapaths and their testbenches. Unlike the fixed 8-beat single-packet source it supersedes, it honours backpressure fully, supports multi-packet bursts and reports busy/done status.

## Interface
Parameters:
- DATA_W, 32, tdata width in bits (≥8)
- LEN_W, 8, width of beats-per-packet configuration
- CNT_W, 8, width of packets-per-run configuration
- GAP_W, 4, width of inter-packet gap configuration

Ports:
- aclk  in  1  clock; everything is synchronous to its rising edge
- areset_n  in  1  asynchronous active-low reset
- start  in  1  run request; sampled only in IDLE
- cfg_pkt_len  in  LEN_W  beats per packet; 0 is treated as 1
- cfg_pkt_cnt  in  CNT_W  packets per run
- cfg_seed  in  DATA_W  tdata of the first beat of the run
- cfg_gap  in  GAP_W  idle cycles between packets; ignored unless the gap feature is compiled in
- m_axis_tvalid  out  1  beat valid
- m_axis_tready  in  1  downstream ready
- m_axis_tdata  out  DATA_W  beat payload
- m_axis_tlast  out  1  last beat of packet
- busy  out  1  run in progress
- done  out  1  one-cycle pulse at run completion

## Operation
- cfg_* are latched on the cycle start is accepted. Changes during a run have no effect.
- States:
  - IDLE → SEND on accepted start with cfg_pkt_cnt≠0.
  - SEND → GAP after a tlast handshake when packets remain and the latched gap≠0.
  - SEND → SEND (back-to-back) after a tlast handshake when packets remain and gap=0.
  - SEND → IDLE after the tlast handshake of the final packet.
  - GAP → SEND when the gap counter expires.
- start with cfg_pkt_cnt=0: no beats are issued, busy stays 0, and done pulses on the next cycle.
- start while busy is ignored. This includes a start in the same cycle as the final handshake.
- Payload:
  - A word register is loaded with cfg_seed at start and increments by 1 on every handshake (tvalid&tready).
  - It continues across packet boundaries and wraps modulo 2^DATA_W.
  - m_axis_tdata = word register while tvalid=1, and 0 otherwise.
- Counters:
  - The beat counter runs 0..len-1 and resets on each tlast handshake.
  - The packet counter counts accepted tlast beats up to cfg_pkt_cnt.
  - Both are sized to LEN_W / CNT_W. Maximum values (2^LEN_W−1 beats, 2^CNT_W−1 packets) must work without overflow.
- m_axis_tlast = 1 exactly when tvalid=1 and the beat counter = len−1. With len=1, every beat carries tlast.
- busy = 1 from the cycle after start is accepted through the cycle of the final handshake, inclusive.

## Timing
- All outputs are registered.
- Reset values: tvalid=0, tdata=0, tlast=0, busy=0, done=0, state=IDLE. Reset takes effect immediately and asynchronously.
- Reset mid-run: the stream is abandoned without tlast and no done pulse is issued.
- Start latency: start accepted at edge N gives tvalid=1 and busy=1 after edge N, so the first beat is presented in cycle N+1.
- Handshake rules:
  - Once tvalid=1 it stays 1, and tdata/tlast stay stable, until tready=1.
  - tvalid never depends combinationally on tready.
- Throughput: one beat per cycle with tready held high, including across packet boundaries when gap=0.
- Gap: after a tlast handshake, tvalid is 0 for exactly cfg_gap cycles, then the next packet's first beat is presented.
- Completion: the final tlast handshake at edge M gives tvalid=0, busy=0 and done=1 for cycle M+1 only.
- A new start may be accepted in cycle M+1.

## Configuration
- AXIS_PKT_GEN_GAP_EN defined: the GAP state and gap counter exist, and cfg_gap sets the inter-packet idle cycles.
- AXIS_PKT_GEN_GAP_EN undefined: no GAP state. cfg_gap is present but unused, and packets are always back-to-back.

## Test plan
- seed=0x1000, len=4, cnt=1, tready=1 → beats 0x1000..0x1003 in 4 consecutive cycles, tlast on 0x1003, done one cycle after, busy high for 4 cycles.
- seed=0xFFFFFFFE, len=3, cnt=2, gap=0 → tdata FFFFFFFE, FFFFFFFF, 0, 1, 2, 3 with no bubble and tlast on 0 and 3 (wrap plus back-to-back).
- len=5, cnt=1, tready toggled pseudo-randomly → exactly 5 handshakes; tdata/tlast stable on every stalled cycle; tvalid never drops while unaccepted.
- len=0, cnt=3, and separately cnt=0 → three single-beat packets each with tlast; cnt=0 gives no beats and done one cycle after start.
- GAP_EN defined, len=2, cnt=3, gap=3 → exactly 3 tvalid=0 cycles between packets. With GAP_EN undefined, the same stimulus gives zero idle cycles.
- Assert areset_n low mid-packet, then release → tvalid/busy/done go 0 immediately with no done pulse; a subsequent start (seed=0xA0, len=2, cnt=1) runs normally with beats A0, A1.
